// File: rtl/imm_gen_pipe_pkg.sv
// imm_pkg: immediate format encodings and handshake buffer states shared by the immediate generator.
package imm_pkg;
  localparam int INSTR_W = 32;
  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_ZIMM, IMM_RSV
  } imm_src_e;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;
endpackage

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract: combinational immediate format mux with sign/zero extension to XLEN.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  input  imm_src_e           src_i,
  output logic [XLEN-1:0]    imm_o,
  output logic               illegal_o
);
  logic s;
  logic unused_opcode;
  assign s = instr_i[31];
  assign unused_opcode = ^instr_i[6:0];
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_extract: XLEN must be 32 or 64");
  end
  always_comb begin
    imm_o = '0;
    case (src_i)
      IMM_I:     imm_o = {{(XLEN-12){s}}, instr_i[31:20]};
      IMM_S:     imm_o = {{(XLEN-12){s}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:     imm_o = {{(XLEN-13){s}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:     imm_o = {{(XLEN-20){s}}, instr_i[31:12]} << 12;
      IMM_J:     imm_o = {{(XLEN-21){s}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      IMM_SHAMT: imm_o = {{(XLEN-6){1'b0}}, (XLEN == 32) ? 1'b0 : instr_i[25], instr_i[24:20]};
      IMM_ZIMM:  imm_o = {{(XLEN-5){1'b0}}, instr_i[19:15]};
      default:   imm_o = '0;
    endcase
  end
  // A 5-bit shamt field on RV32 makes bit 25 reserved.
  assign illegal_o = (src_i == IMM_RSV) | ((src_i == IMM_SHAMT) & (XLEN == 32) & instr_i[25]);
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with valid/ready handshake and one-entry skid buffer.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [2:0]         in_imm_src,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic               out_illegal
);
  state_e            state_q, state_d;
  logic [XLEN-1:0]   ext_imm, out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic              ext_ill, out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
  logic              accept, load_out, load_skid, pop_skid;
  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr_i   (in_instr),
    .src_i     (imm_src_e'(in_imm_src)),
    .imm_o     (ext_imm),
    .illegal_o (ext_ill)
  );
  assign in_ready    = SKID_EN ? (state_q != ST_TWO) : (out_ready | (state_q == ST_EMPTY));
  assign out_valid   = state_q != ST_EMPTY;
  assign out_imm     = out_imm_q;
  assign out_illegal = out_ill_q;
  // Flush drops a same-cycle accept; held data stays but is no longer valid.
  always_comb begin
    accept     = in_valid & in_ready;
    load_out   = accept & ~flush & ((state_q == ST_EMPTY) | out_ready);
    load_skid  = accept & ~flush & (state_q == ST_ONE) & ~out_ready;
    pop_skid   = (state_q == ST_TWO) & out_ready & ~flush;
    out_imm_d  = load_out ? ext_imm : pop_skid ? skid_imm_q : out_imm_q;
    out_ill_d  = load_out ? ext_ill : pop_skid ? skid_ill_q : out_ill_q;
    skid_imm_d = load_skid ? ext_imm : skid_imm_q;
    skid_ill_d = load_skid ? ext_ill : skid_ill_q;
    state_d    = flush ? ST_EMPTY :
                 load_out ? ST_ONE :
                 load_skid ? ST_TWO :
                 pop_skid ? ST_ONE :
                 ((state_q == ST_ONE) & out_ready) ? ST_EMPTY : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_imm_q  <= '0;
      out_ill_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_imm_q  <= out_imm_d;
      out_ill_q  <= out_ill_d;
      skid_imm_q <= skid_imm_d;
      skid_ill_q <= skid_ill_d;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scenario tasks with inline checks plus a scoreboard monitor on the 32-bit instance.
module tb_imm_gen_pipe;
  logic        clk = 0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  int          checks = 0, passed = 0, push_cnt = 0;
  bit          mon_en = 0;
  logic [32:0] q[$];
  logic        stall_q = 0;
  logic [32:0] held;
  logic [32:0] exp_e;
  logic [64:0] m;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_illegal(out_illegal));

  imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_imm_src(in_imm_src), .flush(flush), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_illegal(out_illegal64));

  function automatic logic [64:0] model(input logic [31:0] i, input logic [2:0] src, input bit x64);
    logic signed [63:0] v;
    logic ill;
    v = '0;
    ill = 1'b0;
    case (src)
      3'd0: v = $signed(i[31:20]);
      3'd1: v = $signed({i[31:25], i[11:7]});
      3'd2: v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
      3'd3: v = $signed({i[31:12], 12'b0});
      3'd4: v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      3'd5: begin
        v = x64 ? 64'(i[25:20]) : 64'(i[24:20]);
        ill = !x64 && i[25];
      end
      3'd6: v = 64'(i[19:15]);
      default: ill = 1'b1;
    endcase
    return {ill, v};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_q) begin
        checks++;
        if (out_valid === 1'b1 && {out_illegal, out_imm} === held) passed++;
        else $display("FAIL hold: got valid=%b imm=%h ill=%b, want imm=%h ill=%b", out_valid, out_imm, out_illegal, held[31:0], held[32]);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) $display("FAIL scoreboard: unexpected output imm=%h", out_imm);
        else begin
          exp_e = q.pop_front();
          if ({out_illegal, out_imm} === exp_e) passed++;
          else $display("FAIL scoreboard: got imm=%h ill=%b, want imm=%h ill=%b", out_imm, out_illegal, exp_e[31:0], exp_e[32]);
        end
      end
      if (rst || flush) q.delete();
      else if (in_valid && in_ready) begin
        m = model(in_instr, in_imm_src, 1'b0);
        q.push_back({m[64], m[31:0]});
        push_cnt++;
      end
      stall_q <= out_valid & ~out_ready & ~flush & ~rst;
      held    <= {out_illegal, out_imm};
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 0; flush = 0; out_ready = 1; in_instr = '0; in_imm_src = '0;
    step; step;
    rst = 0;
    mon_en = 1;
    checks++;
    if (out_valid === 1'b0 && out_imm === 32'h0 && out_illegal === 1'b0 && in_ready === 1'b1) passed++;
    else $display("FAIL reset: got valid=%b imm=%h ill=%b rdy=%b, want 0 0 0 1", out_valid, out_imm, out_illegal, in_ready);
  endtask

  task automatic test_formats;
    logic [31:0] ins [7] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h123452B7, 32'h001000EF, 32'h3400F073, 32'h12345678};
    logic [2:0]  src [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    logic [31:0] exp [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'h00000800, 32'h00000001, 32'h0};
    logic        ill [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (out_valid === 1'b0) passed++;
      else $display("FAIL fmt%0d_idle: got valid=%b, want 0", k, out_valid);
      in_valid = 1; in_instr = ins[k]; in_imm_src = src[k];
      step;
      in_valid = 0;
      checks++;
      if (out_valid === 1'b1 && out_imm === exp[k] && out_illegal === ill[k]) passed++;
      else $display("FAIL fmt%0d: got valid=%b imm=%h ill=%b, want 1 %h %b", k, out_valid, out_imm, out_illegal, exp[k], ill[k]);
      step;
    end
  endtask

  task automatic test_shamt;
    logic [31:0] ins [3] = '{32'h01F01093, 32'h02001093, 32'h800002B7};
    logic [2:0]  src [3] = '{3'd5, 3'd5, 3'd3};
    logic [31:0] e32 [3] = '{32'h1F, 32'h0, 32'h80000000};
    logic        i32 [3] = '{1'b0, 1'b1, 1'b0};
    logic [63:0] e64 [3] = '{64'h1F, 64'h20, 64'hFFFFFFFF80000000};
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_instr = ins[k]; in_imm_src = src[k];
      step;
      in_valid = 0;
      checks++;
      if (out_valid === 1'b1 && out_imm === e32[k] && out_illegal === i32[k]) passed++;
      else $display("FAIL shamt32_%0d: got imm=%h ill=%b, want %h %b", k, out_imm, out_illegal, e32[k], i32[k]);
      checks++;
      if (out_valid64 === 1'b1 && out_imm64 === e64[k] && out_illegal64 === 1'b0) passed++;
      else $display("FAIL shamt64_%0d: got imm=%h ill=%b, want %h 0", k, out_imm64, out_illegal64, e64[k]);
      step;
    end
  endtask

  task automatic test_backpressure;
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00100013; in_imm_src = 3'd0;
    step;
    in_instr = 32'h00200013;
    step;
    in_instr = 32'h00300013;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (in_ready === 1'b0 && out_valid === 1'b1 && out_imm === 32'h1) passed++;
      else $display("FAIL bp_stall%0d: got rdy=%b valid=%b imm=%h, want 0 1 1", k, in_ready, out_valid, out_imm);
      if (k == 0) step;
    end
    out_ready = 1;
    step;
    checks++;
    if (out_valid === 1'b1 && out_imm === 32'h2 && in_ready === 1'b1) passed++;
    else $display("FAIL bp_B: got valid=%b imm=%h rdy=%b, want 1 2 1", out_valid, out_imm, in_ready);
    step;
    in_valid = 0;
    checks++;
    if (out_valid === 1'b1 && out_imm === 32'h3) passed++;
    else $display("FAIL bp_C: got valid=%b imm=%h, want 1 3", out_valid, out_imm);
    step;
    checks++;
    if (out_valid === 1'b0) passed++;
    else $display("FAIL bp_drain: got valid=%b, want 0", out_valid);
  endtask

  task automatic test_flush;
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00500013; in_imm_src = 3'd0;
    step;
    in_instr = 32'h00600013;
    step;
    in_instr = 32'h00700013; flush = 1;
    checks++;
    if (in_ready === 1'b0) passed++;
    else $display("FAIL flush_two_rdy: got rdy=%b, want 0", in_ready);
    step;
    flush = 0; in_valid = 0; out_ready = 1;
    checks++;
    if (out_valid === 1'b0 && in_ready === 1'b1) passed++;
    else $display("FAIL flush_two: got valid=%b rdy=%b, want 0 1", out_valid, in_ready);
    for (int k = 0; k < 3; k++) begin
      step;
      checks++;
      if (out_valid === 1'b0) passed++;
      else $display("FAIL flush_quiet%0d: got valid=%b imm=%h, want valid 0", k, out_valid, out_imm);
    end
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00800013;
    step;
    in_instr = 32'h00900013; flush = 1;
    checks++;
    if (in_ready === 1'b1) passed++;
    else $display("FAIL flush_one_rdy: got rdy=%b, want 1", in_ready);
    step;
    flush = 0; in_valid = 0; out_ready = 1;
    checks++;
    if (out_valid === 1'b0) passed++;
    else $display("FAIL flush_one: got valid=%b, want 0", out_valid);
    step;
  endtask

  task automatic test_reset_mid;
    out_ready = 0;
    in_valid = 1; in_instr = 32'h7FF00013; in_imm_src = 3'd0;
    step;
    in_instr = 32'h80000013;
    step;
    in_valid = 0; rst = 1;
    step;
    rst = 0;
    checks++;
    if (out_valid === 1'b0 && out_imm === 32'h0 && in_ready === 1'b1 && out_imm64 === 64'h0) passed++;
    else $display("FAIL reset_mid: got valid=%b imm=%h rdy=%b imm64=%h, want 0 0 1 0", out_valid, out_imm, in_ready, out_imm64);
    out_ready = 1;
    step;
  endtask

  task automatic test_soak;
    int cyc = 0;
    int start = push_cnt;
    while (push_cnt - start < 10000 && cyc < 60000) begin
      in_valid   = ($urandom_range(0, 1) == 1);
      in_instr   = in_valid ? $urandom : 'x;
      in_imm_src = 3'($urandom_range(0, 7));
      out_ready  = ($urandom_range(0, 3) != 0);
      step;
      cyc++;
    end
    in_valid = 0; in_instr = '0; out_ready = 1;
    checks++;
    if (push_cnt - start >= 10000) passed++;
    else $display("FAIL soak_budget: got %0d transactions, want 10000", push_cnt - start);
    for (int k = 0; k < 4; k++) step;
    checks++;
    if (q.size() == 0 && out_valid === 1'b0) passed++;
    else $display("FAIL soak_drain: got %0d pending valid=%b, want 0 0", q.size(), out_valid);
  endtask

  initial begin
    test_reset;
    test_formats;
    test_shamt;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_soak;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
